// File: rtl/morra_match_ctrl.sv
// morra_match_ctrl: two-player Morra Cinese (rock-paper-scissors) match controller.
//
// A match begins on START, which latches a round limit TO_PLAY = CFG + ROUND_BASE.
// Moves are evaluated each cycle while in PLAY, and the round result appears one
// cycle later. The match ends in either of two cases:
//   - the counted-round limit is reached, or
//   - at least MIN_ROUNDS rounds have been counted and one player leads by LEAD.
// The final result is held in DONE until the next START or RST.
//
// Ports:
//   clk            clock
//   RST            synchronous active-high reset (has priority over START)
//   START          begin or restart a match; samples CFG
//   CFG[CFG_W-1:0] match-length code
//   P1, P2 [1:0]   moves: 00 none, 01 rock, 10 paper, 11 scissors
//   ROUND [1:0]    last round: 00 not counted, 01 P1, 10 P2, 11 tie
//   GAME  [1:0]    match result: 00 running/idle, 01 P1, 10 P2, 11 draw
//   BUSY           match in progress
//   SCORE1, SCORE2 rounds won by each player
//   PLAYED         counted rounds, ties included
//
// Optional build macro MORRA_REPEAT_BAN_EN: when the last round had a winner,
// that player may not repeat the winning move on the next round. A banned round
// is treated as invalid.
module morra_match_ctrl #(
  parameter int CFG_W      = 4,
  parameter int ROUND_BASE = 4,
  parameter int CNT_W      = 5,
  parameter int MIN_ROUNDS = 4,
  parameter int LEAD       = 2
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             START,
  input  logic [CFG_W-1:0] CFG,
  input  logic [1:0]       P1,
  input  logic [1:0]       P2,
  output logic [1:0]       ROUND,
  output logic [1:0]       GAME,
  output logic             BUSY,
  output logic [CNT_W-1:0] SCORE1,
  output logic [CNT_W-1:0] SCORE2,
  output logic [CNT_W-1:0] PLAYED
);

  if (ROUND_BASE + (2 ** CFG_W) - 1 >= (2 ** CNT_W)) begin : g_bad_cnt_w
    $error("morra_match_ctrl: CNT_W too small for ROUND_BASE + 2**CFG_W - 1");
  end
  if (LEAD < 1) begin : g_bad_lead
    $error("morra_match_ctrl: LEAD must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [1:0]       round_q, round_n;
  logic [1:0]       game_q, game_n;
  logic             busy_q;
  logic [CNT_W-1:0] score1_q, score1_n;
  logic [CNT_W-1:0] score2_q, score2_n;
  logic [CNT_W-1:0] played_q, played_n;
  logic [CNT_W-1:0] to_play_q, to_play_n;
  logic [CNT_W-1:0] diff;
  logic             valid, p1_win, p2_win;

`ifdef MORRA_REPEAT_BAN_EN
  // {player (0 = P1, 1 = P2), move}. A move field of 00 means no ban is active.
  logic [2:0] ban_q, ban_n;
`endif

  always_comb begin
    state_n   = state;
    round_n   = '0;
    game_n    = game_q;
    score1_n  = score1_q;
    score2_n  = score2_q;
    played_n  = played_q;
    to_play_n = to_play_q;
    diff      = '0;
    valid     = 1'b0;
    p1_win    = 1'b0;
    p2_win    = 1'b0;
`ifdef MORRA_REPEAT_BAN_EN
    ban_n     = ban_q;
`endif
    if (START) begin
      to_play_n = CNT_W'(CFG) + CNT_W'(ROUND_BASE);
      score1_n  = '0;
      score2_n  = '0;
      played_n  = '0;
      game_n    = '0;
      state_n   = PLAY;
`ifdef MORRA_REPEAT_BAN_EN
      ban_n     = '0;
`endif
    end else if (state == PLAY) begin
      valid  = (P1 != 2'b00) && (P2 != 2'b00);
`ifdef MORRA_REPEAT_BAN_EN
      if (ban_q[1:0] != 2'b00 &&
          (ban_q[2] ? (P2 == ban_q[1:0]) : (P1 == ban_q[1:0])))
        valid = 1'b0;
`endif
      p1_win = ({P1, P2} == 4'b0111) || ({P1, P2} == 4'b1001) || ({P1, P2} == 4'b1110);
      p2_win = ({P1, P2} == 4'b1101) || ({P1, P2} == 4'b0110) || ({P1, P2} == 4'b1011);
      if (valid) begin
        played_n = played_q + CNT_W'(1);
        if (p1_win) begin
          score1_n = score1_q + CNT_W'(1);
          round_n  = 2'b01;
`ifdef MORRA_REPEAT_BAN_EN
          ban_n    = {1'b0, P1};
`endif
        end else if (p2_win) begin
          score2_n = score2_q + CNT_W'(1);
          round_n  = 2'b10;
`ifdef MORRA_REPEAT_BAN_EN
          ban_n    = {1'b1, P2};
`endif
        end else begin
          round_n  = 2'b11;
`ifdef MORRA_REPEAT_BAN_EN
          ban_n    = '0;
`endif
        end
        // End check works on the post-update counts so the final round is
        // reported in the same cycle as the result.
        diff = (score1_n >= score2_n) ? (score1_n - score2_n) : (score2_n - score1_n);
        if (played_n == to_play_q ||
            (played_n >= CNT_W'(MIN_ROUNDS) && diff >= CNT_W'(LEAD))) begin
          state_n = DONE;
          if (score1_n > score2_n)      game_n = 2'b01;
          else if (score2_n > score1_n) game_n = 2'b10;
          else                          game_n = 2'b11;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state     <= IDLE;
      round_q   <= '0;
      game_q    <= '0;
      busy_q    <= 1'b0;
      score1_q  <= '0;
      score2_q  <= '0;
      played_q  <= '0;
      to_play_q <= '0;
`ifdef MORRA_REPEAT_BAN_EN
      ban_q     <= '0;
`endif
    end else begin
      state     <= state_n;
      round_q   <= round_n;
      game_q    <= game_n;
      busy_q    <= (state_n == PLAY);
      score1_q  <= score1_n;
      score2_q  <= score2_n;
      played_q  <= played_n;
      to_play_q <= to_play_n;
`ifdef MORRA_REPEAT_BAN_EN
      ban_q     <= ban_n;
`endif
    end
  end

  assign ROUND  = round_q;
  assign GAME   = game_q;
  assign BUSY   = busy_q;
  assign SCORE1 = score1_q;
  assign SCORE2 = score2_q;
  assign PLAYED = played_q;

endmodule

// File: tb/tb_morra_match_ctrl.sv
// tb_morra_match_ctrl: directed bench for morra_match_ctrl with default parameters
// (TO_PLAY = CFG + 4, MIN_ROUNDS = 4, LEAD = 2). Expected values are hand-computed.
// The repeat-ban scenario follows MORRA_REPEAT_BAN_EN; the other scenarios assume
// the default build.
module tb_morra_match_ctrl;

  logic       clk = 1'b0;
  logic       RST = 1'b1;
  logic       START = 1'b0;
  logic [3:0] CFG = '0;
  logic [1:0] P1 = '0;
  logic [1:0] P2 = '0;
  logic [1:0] ROUND;
  logic [1:0] GAME;
  logic       BUSY;
  logic [4:0] SCORE1;
  logic [4:0] SCORE2;
  logic [4:0] PLAYED;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  morra_match_ctrl #(
    .CFG_W(4), .ROUND_BASE(4), .CNT_W(5), .MIN_ROUNDS(4), .LEAD(2)
  ) dut (
    .clk(clk), .RST(RST), .START(START), .CFG(CFG), .P1(P1), .P2(P2),
    .ROUND(ROUND), .GAME(GAME), .BUSY(BUSY),
    .SCORE1(SCORE1), .SCORE2(SCORE2), .PLAYED(PLAYED)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One rising edge, then settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [3:0] cfg, input logic [1:0] m1, input logic [1:0] m2);
    START = 1'b1; CFG = cfg; P1 = m1; P2 = m2;
    step();
    START = 1'b0; P1 = '0; P2 = '0;
  endtask

  task automatic play(input logic [1:0] m1, input logic [1:0] m2, input int exp_round,
                      input string tag);
    P1 = m1; P2 = m2;
    step();
    P1 = '0; P2 = '0;
    check(tag, int'(ROUND), exp_round);
  endtask

  task automatic counts(input string tag, input int s1, input int s2, input int pl,
                        input int game, input int busy);
    check({tag, ".score1"}, int'(SCORE1), s1);
    check({tag, ".score2"}, int'(SCORE2), s2);
    check({tag, ".played"}, int'(PLAYED), pl);
    check({tag, ".game"},   int'(GAME),   game);
    check({tag, ".busy"},   int'(BUSY),   busy);
  endtask

  initial begin
    // Reset state, then moves in IDLE are ignored.
    step(); step();
    check("rst.round", int'(ROUND), 0);
    counts("rst", 0, 0, 0, 0, 0);
    RST = 1'b0;
    play(2'b10, 2'b01, 0, "idle.round");
    counts("idle", 0, 0, 0, 0, 0);

    // Scenario 1: CFG=0 -> TO_PLAY=4; a lead of 2 after 2 rounds does not end it.
    start(4'd0, 2'b00, 2'b00);
    counts("s1.start", 0, 0, 0, 0, 1);
    play(2'b10, 2'b01, 1, "s1.r1");
    play(2'b01, 2'b11, 1, "s1.r2");
    counts("s1.r2", 2, 0, 2, 0, 1);
    play(2'b01, 2'b01, 3, "s1.r3");
    play(2'b11, 2'b11, 3, "s1.r4");
    counts("s1.end", 2, 0, 4, 1, 0);

    // Scenario 2: moves in the START cycle are ignored; draw at the round limit.
    start(4'd0, 2'b10, 2'b01);
    check("s2.start.round", int'(ROUND), 0);
    counts("s2.start", 0, 0, 0, 0, 1);
    play(2'b10, 2'b01, 1, "s2.r1");
    play(2'b01, 2'b10, 2, "s2.r2");
    play(2'b11, 2'b10, 1, "s2.r3");
    counts("s2.r3", 2, 1, 3, 0, 1);
    play(2'b10, 2'b11, 2, "s2.r4");
    counts("s2.end", 2, 2, 4, 3, 0);
    play(2'b10, 2'b01, 0, "s2.done.round");
    counts("s2.done", 2, 2, 4, 3, 0);

    // Scenario 3: CFG=15 -> TO_PLAY=19; P2 ends it early on the lead at round 4.
    start(4'd15, 2'b00, 2'b00);
    for (int i = 0; i < 3; i++) play(2'b01, 2'b10, 2, "s3.r");
    counts("s3.r3", 0, 3, 3, 0, 1);
    play(2'b01, 2'b10, 2, "s3.r4");
    counts("s3.end", 0, 4, 4, 2, 0);

    // Scenario 4: a lead of only 1 at MIN_ROUNDS continues; a lead of 2 then ends it.
    start(4'd15, 2'b00, 2'b00);
    play(2'b10, 2'b01, 1, "s4.r1");
    for (int i = 0; i < 3; i++) play(2'b01, 2'b01, 3, "s4.tie");
    counts("s4.r4", 1, 0, 4, 0, 1);
    play(2'b10, 2'b01, 1, "s4.r5");
    counts("s4.end", 2, 0, 5, 1, 0);

    // Scenario 5: invalid moves; then restart mid-match with CFG=3 -> TO_PLAY=7.
    start(4'd0, 2'b00, 2'b00);
    play(2'b00, 2'b10, 0, "s5.inv1");
    play(2'b01, 2'b00, 0, "s5.inv2");
    counts("s5.inv", 0, 0, 0, 0, 1);
    play(2'b10, 2'b01, 1, "s5.r1");
    play(2'b11, 2'b11, 3, "s5.r2");
    counts("s5.mid", 1, 0, 2, 0, 1);
    start(4'd3, 2'b00, 2'b00);
    counts("s5.restart", 0, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) play(2'b10, 2'b10, 3, "s5.tie");
    counts("s5.r6", 0, 0, 6, 0, 1);
    play(2'b10, 2'b10, 3, "s5.r7");
    counts("s5.end", 0, 0, 7, 3, 0);

    // Scenario 6: RST together with START wins.
    start(4'd0, 2'b00, 2'b00);
    play(2'b10, 2'b01, 1, "s6.r1");
    RST = 1'b1; START = 1'b1;
    step();
    RST = 1'b0; START = 1'b0;
    check("s6.round", int'(ROUND), 0);
    counts("s6", 0, 0, 0, 0, 0);

    // Scenario 7: repeating a winning move.
    start(4'd0, 2'b00, 2'b00);
    play(2'b10, 2'b01, 1, "s7.r1");
`ifdef MORRA_REPEAT_BAN_EN
    play(2'b10, 2'b01, 0, "s7.r2");
    counts("s7.r2", 1, 0, 1, 0, 1);
    play(2'b11, 2'b10, 1, "s7.r3");
    counts("s7.r3", 2, 0, 2, 0, 1);
`else
    play(2'b10, 2'b01, 1, "s7.r2");
    counts("s7.r2", 2, 0, 2, 0, 1);
    play(2'b11, 2'b10, 1, "s7.r3");
    counts("s7.r3", 3, 0, 3, 0, 1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
